ram_arbiter: RTL and testbench

//  Shares one simple dual-port ram instance between NREQ requesters (CPU fetch, CPU data, loader).

---
 rtl/ram_arb_pkg.sv | 41 ++++
 rtl/ram_arb_rr_pick.sv | 32 +++
 rtl/ram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the ram_arbiter block.
//   state_t     : arbiter FSM state (IDLE / LOCKED)
//   idx_width() : bits needed to index NREQ requesters (minimum 1)
//   rr_pick()   : one-hot winner, first requester at or after ptr, mod nreq
package ram_arb_pkg;

    localparam int unsigned MAX_REQ = 4;
    localparam int unsigned PTR_W   = 2;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    // Rotating priority search: scan nreq slots starting at ptr, wrapping.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [PTR_W-1:0]   ptr,
        input int unsigned        nreq
    );
        logic [MAX_REQ-1:0] win;
        logic               found;
        int unsigned        idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = (32'(ptr) + k) % nreq;
            if (!found && (k < nreq) && req[PTR_W'(idx)]) begin
                win[PTR_W'(idx)] = 1'b1;
                found            = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/ram_arb_rr_pick.sv
// Combinational rotating-priority picker.
//   req       : per-requester request vector
//   ptr       : search start index (tie to 0 for fixed lowest-index priority)
//   win_oh_c  : one-hot winner (all zero when nobody requests)
//   win_idx_c : binary index of the winner (0 when nobody requests)
module ram_arb_rr_pick
    import ram_arb_pkg::*;
#(
    parameter  int unsigned NREQ  = 2,
    localparam int unsigned IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  win_oh_c,
    output logic [IDX_W-1:0] win_idx_c
);

    logic [MAX_REQ-1:0] win_full;

    // Pick in the fixed-width helper, then narrow and encode.
    always_comb begin
        win_full  = rr_pick(MAX_REQ'(req), PTR_W'(ptr), NREQ);
        win_oh_c  = win_full[NREQ-1:0];
        win_idx_c = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (win_full[i]) begin
                win_idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one simple dual-port ram between NREQ requesters, one access per
// cycle, round-robin, with an optional lock that keeps ownership for bursts.
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed lowest-index priority
// (no rotation pointer); LOCKED behaviour is the same in both builds.
// Ports:
//   clk, resetn          clock (also the ram's wclk/rclk), async active-low reset
//   req/we/lock [NREQ]   per-requester request, write select, burst lock
//   addr, wdata          flattened per-requester address / write data
//   gnt                  one-hot combinational accept for this cycle
//   rvalid, rdata        one-hot registered read return, ram dout pass-through
//   ram_we/waddr/din     ram write port
//   ram_raddr, ram_dout  ram read port
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            we,
    input  logic [NREQ-1:0]            lock,
    input  logic [NREQ*ADDR_WIDTH-1:0] addr,
    input  logic [NREQ*DATA_WIDTH-1:0] wdata,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       ram_we,
    output logic [ADDR_WIDTH-1:0]      ram_waddr,
    output logic [DATA_WIDTH-1:0]      ram_din,
    output logic [ADDR_WIDTH-1:0]      ram_raddr,
    input  logic [DATA_WIDTH-1:0]      ram_dout
);

    localparam int unsigned IDX_W = idx_width(NREQ);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [NREQ-1:0]        rvalid_q, rvalid_d;
    logic [ADDR_WIDTH-1:0]  raddr_q, raddr_d;

    logic [NREQ-1:0]        win_oh;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       pick_ptr;

    logic [NREQ-1:0]        gnt_c;
    logic                   grant_c;
    logic                   win_lock_c;
    logic                   sel_we_c;
    logic [ADDR_WIDTH-1:0]  sel_addr_c;
    logic [DATA_WIDTH-1:0]  sel_wdata_c;

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Search always starts at requester 0: lowest index wins.
    assign pick_ptr = '0;
`else
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    assign pick_ptr = rr_ptr_q;
`endif

    ram_arb_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req       (req),
        .ptr       (pick_ptr),
        .win_oh_c  (win_oh),
        .win_idx_c (win_idx)
    );

    // Grant selection and IDLE/LOCKED next-state.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        gnt_c      = '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        win_lock_c = |(lock & win_oh);

        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_c = win_oh;
`ifndef RAM_ARB_FIXED_PRIO_EN
                    rr_ptr_d = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
`endif
                    if (win_lock_c) begin
                        owner_d = win_idx;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                gnt_c[owner_q] = req[owner_q];
                // Dropping lock ends the burst whether or not owner requests.
                if (!lock[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // No access may reach the ram while reset is held.
        if (!resetn) begin
            gnt_c = '0;
        end
    end

    // Route the winner's request onto the ram ports.
    always_comb begin
        sel_we_c    = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                sel_we_c    = we[i];
                sel_addr_c  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata_c = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        grant_c   = |gnt_c;
        ram_we    = grant_c & sel_we_c;
        ram_waddr = sel_addr_c;
        ram_din   = sel_wdata_c;
        // Read port keeps the last read address when no read is granted.
        ram_raddr = (grant_c & ~sel_we_c) ? sel_addr_c : raddr_q;
        raddr_d   = ram_raddr;
        rvalid_d  = (grant_c & ~sel_we_c) ? gnt_c : '0;
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rvalid_q <= '0;
            raddr_q  <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rvalid_q <= rvalid_d;
            raddr_q  <= raddr_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign gnt    = gnt_c;
    assign rvalid = rvalid_q;
    assign rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a 2-requester and a 4-requester instance, each with
// its own behavioural ram, driven by directed scenarios and random traffic and
// checked cycle by cycle against a transaction-level reference model.
module tb_ram_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 8;
    localparam int unsigned NA = 2;
    localparam int unsigned NB = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // Stimulus per instance (index 0 = NA, 1 = NB), four lanes each.
    logic [3:0]    s_req   [2];
    logic [3:0]    s_we    [2];
    logic [3:0]    s_lock  [2];
    logic [AW-1:0] s_addr  [2][4];
    logic [DW-1:0] s_wdata [2][4];

    logic [NA*AW-1:0] addr_a;
    logic [NA*DW-1:0] wdata_a;
    logic [NB*AW-1:0] addr_b;
    logic [NB*DW-1:0] wdata_b;

    logic [NA-1:0] gnt_a, rvalid_a;
    logic [NB-1:0] gnt_b, rvalid_b;
    logic [DW-1:0] rdata_a, din_a, dout_a, rdata_b, din_b, dout_b;
    logic          we_a, we_b;
    logic [AW-1:0] waddr_a, raddr_a, waddr_b, raddr_b;

    always_comb begin
        for (int unsigned i = 0; i < NA; i++) begin
            addr_a[i*AW +: AW]  = s_addr[0][i];
            wdata_a[i*DW +: DW] = s_wdata[0][i];
        end
        for (int unsigned i = 0; i < NB; i++) begin
            addr_b[i*AW +: AW]  = s_addr[1][i];
            wdata_b[i*DW +: DW] = s_wdata[1][i];
        end
    end

    ram_arbiter #(.NREQ(NA), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut_a (
        .clk(clk), .resetn(resetn),
        .req(s_req[0][NA-1:0]), .we(s_we[0][NA-1:0]), .lock(s_lock[0][NA-1:0]),
        .addr(addr_a), .wdata(wdata_a),
        .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a),
        .ram_we(we_a), .ram_waddr(waddr_a), .ram_din(din_a),
        .ram_raddr(raddr_a), .ram_dout(dout_a)
    );

    ram_arbiter #(.NREQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut_b (
        .clk(clk), .resetn(resetn),
        .req(s_req[1]), .we(s_we[1]), .lock(s_lock[1]),
        .addr(addr_b), .wdata(wdata_b),
        .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b),
        .ram_we(we_b), .ram_waddr(waddr_b), .ram_din(din_b),
        .ram_raddr(raddr_b), .ram_dout(dout_b)
    );

    // Simple dual-port rams with registered read.
    logic [DW-1:0] mem_a [512];
    logic [DW-1:0] mem_b [512];
    always @(posedge clk) begin
        if (we_a) mem_a[waddr_a] <= din_a;
        dout_a <= mem_a[raddr_a];
    end
    always @(posedge clk) begin
        if (we_b) mem_b[waddr_b] <= din_b;
        dout_b <= mem_b[raddr_b];
    end

    // Observed outputs, widened to common lanes.
    logic [3:0]    o_gnt[2], o_rvalid[2];
    logic [DW-1:0] o_rdata[2], o_din[2];
    logic          o_we[2];
    logic [AW-1:0] o_waddr[2], o_raddr[2];
    always_comb begin
        o_gnt[0] = 4'(gnt_a);       o_gnt[1] = gnt_b;
        o_rvalid[0] = 4'(rvalid_a); o_rvalid[1] = rvalid_b;
        o_rdata[0] = rdata_a;       o_rdata[1] = rdata_b;
        o_din[0] = din_a;           o_din[1] = din_b;
        o_we[0] = we_a;             o_we[1] = we_b;
        o_waddr[0] = waddr_a;       o_waddr[1] = waddr_b;
        o_raddr[0] = raddr_a;       o_raddr[1] = raddr_b;
    end

    // Reference model state.
    bit            m_locked[2];
    int unsigned   m_owner[2];
    int unsigned   m_ptr[2];
    logic [3:0]    m_rv[2];
    logic [DW-1:0] m_rdata[2];
    bit            m_rdv[2];
    logic [AW-1:0] m_raddr[2];
    bit            m_rak[2];
    logic [DW-1:0] m_mem[2][512];
    bit            m_memv[2][512];
    logic [3:0]    granted[2];

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    logic [3:0]  exp_g;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic string tg(input string base, input int unsigned d);
        return $sformatf("%s_%s", base, (d == 0) ? "a" : "b");
    endfunction

    // One cycle of the reference model for instance d, checking the DUT.
    task automatic model_cycle(input int unsigned d);
        int unsigned n, start, j;
        int          w;
        logic [3:0]  eg;
        bit          wr;
        logic [AW-1:0] a;
        n  = (d == 0) ? NA : NB;
        eg = '0;
        w  = -1;
        if (!resetn) begin
            m_locked[d] = 0; m_owner[d] = 0; m_ptr[d] = 0;
            m_rv[d] = '0; m_rak[d] = 0; granted[d] = '0;
            check_eq(tg("rst_gnt", d), 32'(o_gnt[d]), 32'd0);
            check_eq(tg("rst_rvalid", d), 32'(o_rvalid[d]), 32'd0);
            check_eq(tg("rst_we", d), 32'(o_we[d]), 32'd0);
            return;
        end
        check_eq(tg("rvalid", d), 32'(o_rvalid[d]), 32'(m_rv[d]));
        if (m_rv[d] != 0 && m_rdv[d])
            check_eq(tg("rdata", d), 32'(o_rdata[d]), 32'(m_rdata[d]));

        if (m_locked[d]) begin
            if (s_req[d][m_owner[d]]) w = int'(m_owner[d]);
        end else begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            start = 0;
`else
            start = m_ptr[d];
`endif
            for (int unsigned k = 0; k < n; k++) begin
                j = (start + k) % n;
                if (w < 0 && s_req[d][j]) w = int'(j);
            end
        end
        if (w >= 0) eg[w] = 1'b1;
        check_eq(tg("gnt", d), 32'(o_gnt[d]), 32'(eg));
        wr = (w >= 0) && s_we[d][w];
        check_eq(tg("ram_we", d), 32'(o_we[d]), 32'(wr));

        if (w >= 0) begin
            a = s_addr[d][w];
            if (wr) begin
                check_eq(tg("waddr", d), 32'(o_waddr[d]), 32'(a));
                check_eq(tg("din", d), 32'(o_din[d]), 32'(s_wdata[d][w]));
                m_mem[d][a]  = s_wdata[d][w];
                m_memv[d][a] = 1;
            end else begin
                check_eq(tg("raddr", d), 32'(o_raddr[d]), 32'(a));
                m_rv[d]    = eg;
                m_rdata[d] = m_mem[d][a];
                m_rdv[d]   = m_memv[d][a];
                m_raddr[d] = a;
                m_rak[d]   = 1;
            end
        end
        if (w < 0 || wr) begin
            m_rv[d] = '0;
            if (m_rak[d]) check_eq(tg("raddr_hold", d), 32'(o_raddr[d]), 32'(m_raddr[d]));
        end

        if (m_locked[d]) begin
            if (!s_lock[d][m_owner[d]]) m_locked[d] = 0;
        end else if (w >= 0) begin
            m_ptr[d] = (32'(w) + 1) % n;
            if (s_lock[d][w]) begin
                m_locked[d] = 1;
                m_owner[d]  = 32'(w);
            end
        end
        granted[d] = eg;
    endtask

    task automatic step();
        #1;
        model_cycle(0);
        model_cycle(1);
    endtask

    task automatic set_req(input int unsigned d, input int unsigned i, input logic rq,
                           input logic w, input logic lk, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd);
        s_req[d][i] = rq; s_we[d][i] = w; s_lock[d][i] = lk;
        s_addr[d][i] = a; s_wdata[d][i] = wd;
    endtask

    // New random requests only for lanes not still waiting for a grant.
    task automatic gen_random();
        for (int unsigned d = 0; d < 2; d++) begin
            for (int unsigned i = 0; i < ((d == 0) ? NA : NB); i++) begin
                if (!(s_req[d][i] && !granted[d][i])) begin
                    s_req[d][i]  = ($urandom_range(0, 1) == 1);
                    s_we[d][i]   = ($urandom_range(0, 2) == 0);
                    s_lock[d][i] = ($urandom_range(0, 3) == 0);
                    s_addr[d][i] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3))
                                                               : AW'(32'h1FC + $urandom_range(0, 3));
                    s_wdata[d][i] = DW'($urandom);
                end
            end
        end
    endtask

    // Let outstanding requests complete, then leave one idle cycle.
    task automatic drain();
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            for (int unsigned d = 0; d < 2; d++) begin
                s_req[d]  = s_req[d] & ~granted[d];
                s_lock[d] = s_lock[d] & s_req[d];
            end
            if (s_req[0] == 0 && s_req[1] == 0) begin
                step();
                return;
            end
            step();
        end
        check_eq("drain_timeout", 32'({s_req[0], s_req[1]}), 32'd0);
    endtask

    initial begin
        for (int unsigned d = 0; d < 2; d++) begin
            s_req[d] = '0; s_we[d] = '0; s_lock[d] = '0; granted[d] = '0;
            m_locked[d] = 0; m_owner[d] = 0; m_ptr[d] = 0; m_rv[d] = '0;
            m_rdata[d] = '0; m_rdv[d] = 0; m_raddr[d] = '0; m_rak[d] = 0;
            for (int unsigned i = 0; i < 4; i++) begin
                s_addr[d][i] = '0; s_wdata[d][i] = '0;
            end
            for (int unsigned k = 0; k < 512; k++) begin
                m_memv[d][k] = 0; m_mem[d][k] = '0;
            end
        end
        resetn = 1'b0;

        // Reset with both requesting: nothing granted, nothing written.
        set_req(0, 0, 1'b1, 1'b0, 1'b0, 9'h010, 8'h00);
        set_req(0, 1, 1'b1, 1'b0, 1'b0, 9'h011, 8'h00);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            step();
            check_eq("t1_gnt", 32'(o_gnt[0]), 32'd0);
        end

        // Release with both still requesting: alternate (or fixed 0).
        @(negedge clk);
        resetn = 1'b1;
        for (int unsigned c = 0; c < 4; c++) begin
            if (c != 0) @(negedge clk);
            step();
`ifdef RAM_ARB_FIXED_PRIO_EN
            exp_g = 4'b0001;
`else
            exp_g = (c % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
            check_eq("t2_gnt", 32'(o_gnt[0]), 32'(exp_g));
        end
        drain();

        // Write 0xA5 @0x1FF from 0, then read it back from 1.
        @(negedge clk);
        set_req(0, 0, 1'b1, 1'b1, 1'b0, 9'h1FF, 8'hA5);
        step();
        check_eq("t3_wgnt", 32'(o_gnt[0]), 32'd1);
        check_eq("t3_we", 32'(o_we[0]), 32'd1);
        @(negedge clk);
        s_req[0][0] = 1'b0;
        set_req(0, 1, 1'b1, 1'b0, 1'b0, 9'h1FF, 8'h00);
        step();
        check_eq("t3_rgnt", 32'(o_gnt[0]), 32'd2);
        @(negedge clk);
        s_req[0][1] = 1'b0;
        step();
        check_eq("t3_rvalid", 32'(o_rvalid[0]), 32'd2);
        check_eq("t3_rdata", 32'(o_rdata[0]), 32'hA5);
        drain();

        // Locked burst of three beats from 1 while 0 waits.
        @(negedge clk);
        set_req(0, 1, 1'b1, 1'b0, 1'b1, 9'h020, 8'h00);
        step();
        check_eq("t4_beat1", 32'(o_gnt[0]), 32'd2);
        @(negedge clk);
        set_req(0, 0, 1'b1, 1'b0, 1'b0, 9'h030, 8'h00);
        set_req(0, 1, 1'b1, 1'b1, 1'b1, 9'h021, 8'h5A);
        step();
        check_eq("t4_beat2", 32'(o_gnt[0]), 32'd2);
        @(negedge clk);
        set_req(0, 1, 1'b1, 1'b0, 1'b0, 9'h021, 8'h00);
        step();
        check_eq("t4_beat3", 32'(o_gnt[0]), 32'd2);
        @(negedge clk);
        s_req[0][1] = 1'b0;
        step();
        check_eq("t4_after", 32'(o_gnt[0]), 32'd1);
        drain();

        // Reset while locked with a read in flight.
        @(negedge clk);
        set_req(0, 1, 1'b1, 1'b0, 1'b1, 9'h1FF, 8'h00);
        step();
        check_eq("t5_gnt", 32'(o_gnt[0]), 32'd2);
        @(negedge clk);
        resetn = 1'b0;
        s_req[0] = '0;
        s_lock[0] = '0;
        step();
        check_eq("t5_rvalid", 32'(o_rvalid[0]), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        set_req(0, 0, 1'b1, 1'b0, 1'b0, 9'h001, 8'h00);
        set_req(0, 1, 1'b1, 1'b0, 1'b0, 9'h002, 8'h00);
        step();
        check_eq("t5_idle_gnt", 32'(o_gnt[0]), 32'd1);
        drain();

        // Pointer wrap on the four-requester instance.
        @(negedge clk);
        set_req(1, 2, 1'b1, 1'b0, 1'b0, 9'h040, 8'h00);
        step();
        check_eq("t6_gnt2", 32'(o_gnt[1]), 32'h4);
        @(negedge clk);
        s_req[1][2] = 1'b0;
        set_req(1, 0, 1'b1, 1'b0, 1'b0, 9'h041, 8'h00);
        set_req(1, 3, 1'b1, 1'b0, 1'b0, 9'h042, 8'h00);
        step();
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_g = 4'b0001;
`else
        exp_g = 4'b1000;
`endif
        check_eq("t6_wrap", 32'(o_gnt[1]), 32'(exp_g));
        @(negedge clk);
        s_req[1] = s_req[1] & ~granted[1];
        step();
        check_eq("t6_next", 32'(o_gnt[1]), 32'(~exp_g & 4'b1001));
        drain();

        // Random traffic with one reset pulse in the middle.
        for (int unsigned c = 0; c < 600; c++) begin
            @(negedge clk);
            gen_random();
            resetn = (c != 300);
            step();
        end
        resetn = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
